// File: rtl/agex_br_resolve.sv
// AGEX branch resolution: registered FE outcome bus, redirect-driven squash window.
// Optional perf counters are built when BR_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | AGEX instructions are live
// SQUASH | squash_cnt != 0, AGEX instruction is wrong-path and killed
module agex_br_resolve #(
    parameter int SQUASH_DEPTH = 2,
    parameter int PHT_IDX_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_AGEX,
    input  logic                      is_cond_AGEX,
    input  logic                      is_jal_AGEX,
    input  logic                      is_jalr_AGEX,
    input  logic [2:0]                br_cond_AGEX,
    input  logic [31:0]               rs1_val_AGEX,
    input  logic [31:0]               rs2_val_AGEX,
    input  logic [31:0]               imm_AGEX,
    input  logic [31:0]               PC_AGEX_in,
    input  logic [31:0]               pcplus_AGEX_in,
    input  logic [31:0]               pred_pc_AGEX,
    input  logic [PHT_IDX_BITS-1:0]   pht_idx_AGEX,
    output logic [98+PHT_IDX_BITS:0]  from_AGEX_to_FE,
    output logic                      squash_AGEX,
    output logic [31:0]               br_cnt,
    output logic [31:0]               mispred_cnt
);

    localparam int BUS_W = 99 + PHT_IDX_BITS;
    localparam int CNT_W = $clog2(SQUASH_DEPTH + 1);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   squash_cnt_q, squash_cnt_d;
    logic [BUS_W-1:0]   fe_bus_q, fe_bus_d;

    logic        live, ctrl, cond_true, taken, mispred, is_br, resolve;
    logic [31:0] target, actual_next;

    always_comb begin
        live = valid_AGEX && (squash_cnt_q == '0);
        ctrl = is_cond_AGEX | is_jal_AGEX | is_jalr_AGEX;

        case (br_cond_AGEX)
            3'b000:  cond_true = (rs1_val_AGEX == rs2_val_AGEX);
            3'b001:  cond_true = (rs1_val_AGEX != rs2_val_AGEX);
            3'b100:  cond_true = ($signed(rs1_val_AGEX) <  $signed(rs2_val_AGEX));
            3'b101:  cond_true = ($signed(rs1_val_AGEX) >= $signed(rs2_val_AGEX));
            3'b110:  cond_true = (rs1_val_AGEX <  rs2_val_AGEX);
            3'b111:  cond_true = (rs1_val_AGEX >= rs2_val_AGEX);
            default: cond_true = 1'b0;
        endcase

        taken  = is_jal_AGEX | is_jalr_AGEX | (is_cond_AGEX & cond_true);
        target = is_jalr_AGEX ? ((rs1_val_AGEX + imm_AGEX) & ~32'h1)
                              : (PC_AGEX_in + imm_AGEX);
        actual_next = taken ? target : pcplus_AGEX_in;

        mispred = live && (actual_next != pred_pc_AGEX);
        is_br   = live && ctrl;
        resolve = is_br || mispred;

        // An alias redirect carries no control-flow target; FE takes pcplus.
        if (resolve)
            fe_bus_d = {is_br, mispred, taken, (ctrl ? target : 32'h0),
                        pcplus_AGEX_in, PC_AGEX_in, pht_idx_AGEX};
        else
            fe_bus_d = '0;

        if (mispred)
            squash_cnt_d = CNT_W'(SQUASH_DEPTH);
        else if (squash_cnt_q != '0)
            squash_cnt_d = squash_cnt_q - 1'b1;
        else
            squash_cnt_d = squash_cnt_q;

        state_d = (squash_cnt_d != '0) ? SQUASH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            squash_cnt_q <= '0;
            fe_bus_q     <= '0;
        end else begin
            state_q      <= state_d;
            squash_cnt_q <= squash_cnt_d;
            fe_bus_q     <= fe_bus_d;
        end
    end

    assign from_AGEX_to_FE = fe_bus_q;
    assign squash_AGEX     = (state_q == SQUASH);

`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Counters advance on the same edge that registers the FE fields.
    always_comb begin
        br_cnt_d      = br_cnt_q + {31'h0, is_br};
        mispred_cnt_d = mispred_cnt_q + {31'h0, mispred};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign br_cnt      = 32'h0;
    assign mispred_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_agex_br_resolve.sv
// Directed bench for agex_br_resolve: vector table plus squash/reset/perf sequences.
module tb_agex_br_resolve;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_AGEX, is_cond_AGEX, is_jal_AGEX, is_jalr_AGEX;
    logic [2:0]   br_cond_AGEX;
    logic [31:0]  rs1_val_AGEX, rs2_val_AGEX, imm_AGEX;
    logic [31:0]  PC_AGEX_in, pcplus_AGEX_in, pred_pc_AGEX;
    logic [7:0]   pht_idx_AGEX;
    logic [106:0] from_AGEX_to_FE;
    logic         squash_AGEX;
    logic [31:0]  br_cnt, mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    agex_br_resolve #(.SQUASH_DEPTH(2), .PHT_IDX_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .valid_AGEX(valid_AGEX), .is_cond_AGEX(is_cond_AGEX),
        .is_jal_AGEX(is_jal_AGEX), .is_jalr_AGEX(is_jalr_AGEX),
        .br_cond_AGEX(br_cond_AGEX), .rs1_val_AGEX(rs1_val_AGEX),
        .rs2_val_AGEX(rs2_val_AGEX), .imm_AGEX(imm_AGEX),
        .PC_AGEX_in(PC_AGEX_in), .pcplus_AGEX_in(pcplus_AGEX_in),
        .pred_pc_AGEX(pred_pc_AGEX), .pht_idx_AGEX(pht_idx_AGEX),
        .from_AGEX_to_FE(from_AGEX_to_FE), .squash_AGEX(squash_AGEX),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          va, c, j, jr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, imm, pc, pred;
        logic [7:0]  pht;
        bit          isbr, mis, taken;
        logic [31:0] target;
    } vec_t;

    vec_t v [13];

    function automatic vec_t mk(input bit va, input bit c, input bit j, input bit jr,
                                input logic [2:0] f3, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [31:0] pred,
                                input logic [7:0] pht, input bit isbr, input bit mis,
                                input bit taken, input logic [31:0] target);
        vec_t r;
        r.va = va; r.c = c; r.j = j; r.jr = jr; r.f3 = f3;
        r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc; r.pred = pred; r.pht = pht;
        r.isbr = isbr; r.mis = mis; r.taken = taken; r.target = target;
        return r;
    endfunction

    function automatic logic [106:0] exp_bus(input vec_t x);
        if (!(x.isbr || x.mis)) return '0;
        return {x.isbr, x.mis, x.taken, x.target, x.pc + 32'd4, x.pc, x.pht};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        valid_AGEX = x.va; is_cond_AGEX = x.c; is_jal_AGEX = x.j; is_jalr_AGEX = x.jr;
        br_cond_AGEX = x.f3; rs1_val_AGEX = x.rs1; rs2_val_AGEX = x.rs2; imm_AGEX = x.imm;
        PC_AGEX_in = x.pc; pcplus_AGEX_in = x.pc + 32'd4; pred_pc_AGEX = x.pred;
        pht_idx_AGEX = x.pht;
    endtask

    task automatic go_idle();
        valid_AGEX = 1'b0; is_cond_AGEX = 1'b0; is_jal_AGEX = 1'b0; is_jalr_AGEX = 1'b0;
    endtask

    // One evaluation followed by two idle cycles that cover the whole squash window.
    task automatic apply_vec(input string name, input vec_t x);
        @(negedge clk); drive(x);
        @(posedge clk); #1;
        chk({name, " bus"}, {21'h0, from_AGEX_to_FE}, {21'h0, exp_bus(x)});
        chk({name, " squash1"}, {127'h0, squash_AGEX}, {127'h0, x.mis});
        @(negedge clk); go_idle();
        @(posedge clk); #1;
        chk({name, " squash2"}, {127'h0, squash_AGEX}, {127'h0, x.mis});
        chk({name, " bus_hold"}, {21'h0, from_AGEX_to_FE}, 128'h0);
        @(posedge clk); #1;
        chk({name, " squash_end"}, {127'h0, squash_AGEX}, 128'h0);
    endtask

    vec_t bad_jal, good_jal;

    initial begin
        //         va c  j  jr f3      rs1           rs2    imm          pc            pred          pht    br mis tk target
        v[0]  = mk(1, 1, 0, 0, 3'b000, 32'd5,        32'd5, 32'h20,      32'h100,      32'h104,      8'h11, 1, 1, 1, 32'h120);
        v[1]  = mk(1, 1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h40,      32'h200,      32'h204,      8'h22, 1, 1, 1, 32'h240);
        v[2]  = mk(1, 1, 0, 0, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h40,      32'h200,      32'h204,      8'h23, 1, 0, 0, 32'h240);
        v[3]  = mk(1, 0, 0, 1, 3'b000, 32'h203,      32'd0, 32'h10,      32'h300,      32'h212,      8'h33, 1, 0, 1, 32'h212);
        v[4]  = mk(1, 0, 0, 0, 3'b000, 32'd0,        32'd0, 32'h8,       32'h40,       32'h80,       8'h44, 0, 1, 0, 32'h0);
        v[5]  = mk(1, 1, 0, 0, 3'b001, 32'd3,        32'd3, 32'h100,     32'h400,      32'h404,      8'h55, 1, 0, 0, 32'h500);
        v[6]  = mk(1, 1, 0, 0, 3'b101, 32'hFFFFFFFF, 32'd1, 32'h10,      32'h600,      32'h610,      8'h66, 1, 1, 0, 32'h610);
        v[7]  = mk(1, 1, 0, 0, 3'b111, 32'hFFFFFFFF, 32'd1, 32'h10,      32'h600,      32'h610,      8'h77, 1, 0, 1, 32'h610);
        v[8]  = mk(1, 1, 0, 0, 3'b010, 32'd9,        32'd9, 32'h10,      32'h700,      32'h704,      8'h88, 1, 0, 0, 32'h710);
        v[9]  = mk(1, 0, 1, 0, 3'b000, 32'd0,        32'd0, 32'h20,      32'hFFFFFFF0, 32'h10,       8'h99, 1, 0, 1, 32'h10);
        v[10] = mk(1, 0, 0, 1, 3'b000, 32'hFFFFFFFF, 32'd0, 32'h2,       32'h800,      32'h0,        8'hAA, 1, 0, 1, 32'h0);
        v[11] = mk(1, 0, 0, 0, 3'b000, 32'd0,        32'd0, 32'h8,       32'h900,      32'h904,      8'hBB, 0, 0, 0, 32'h0);
        v[12] = mk(0, 1, 0, 0, 3'b000, 32'd5,        32'd5, 32'h20,      32'hA00,      32'hA04,      8'hCC, 0, 0, 0, 32'h0);

        bad_jal  = mk(1, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h8, 32'h500, 32'h504, 8'h01, 0, 0, 0, 32'h0);
        good_jal = mk(1, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h8, 32'h500, 32'h508, 8'h02, 1, 0, 1, 32'h508);

        reset = 1'b1;
        go_idle();
        drive(v[11]); valid_AGEX = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset bus", {21'h0, from_AGEX_to_FE}, 128'h0);
        chk("reset squash", {127'h0, squash_AGEX}, 128'h0);
        chk("reset br_cnt", {96'h0, br_cnt}, 128'h0);
        chk("reset mispred_cnt", {96'h0, mispred_cnt}, 128'h0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 13; i++) apply_vec($sformatf("vec%0d", i), v[i]);

        // Branches in both squash cycles are dropped; the third resolves.
        @(negedge clk); drive(v[0]);
        @(posedge clk); #1;
        chk("sq bus0", {21'h0, from_AGEX_to_FE}, {21'h0, exp_bus(v[0])});
        chk("sq squash0", {127'h0, squash_AGEX}, 128'h1);
        @(negedge clk); drive(bad_jal);
        @(posedge clk); #1;
        chk("sq bus1", {21'h0, from_AGEX_to_FE}, 128'h0);
        chk("sq squash1", {127'h0, squash_AGEX}, 128'h1);
        @(negedge clk); drive(bad_jal);
        @(posedge clk); #1;
        chk("sq bus2", {21'h0, from_AGEX_to_FE}, 128'h0);
        chk("sq squash2", {127'h0, squash_AGEX}, 128'h0);
        @(negedge clk); drive(good_jal);
        @(posedge clk); #1;
        chk("sq bus3", {21'h0, from_AGEX_to_FE}, {21'h0, exp_bus(good_jal)});
        chk("sq squash3", {127'h0, squash_AGEX}, 128'h0);
        @(negedge clk); go_idle();
        @(posedge clk); #1;

        // Reset in the first squash cycle clears the window immediately.
        @(negedge clk); drive(v[1]);
        @(posedge clk); #1;
        chk("rst_sq squash", {127'h0, squash_AGEX}, 128'h1);
        @(negedge clk); reset = 1'b1; drive(good_jal);
        @(posedge clk); #1;
        chk("rst_sq squash_after", {127'h0, squash_AGEX}, 128'h0);
        chk("rst_sq bus_after", {21'h0, from_AGEX_to_FE}, 128'h0);
        chk("rst_sq br_cnt", {96'h0, br_cnt}, 128'h0);
        @(negedge clk); reset = 1'b0; go_idle();

        apply_vec("perf a", v[5]);
        apply_vec("perf b", v[2]);
        apply_vec("perf c", v[0]);
`ifdef BR_PERF_CNT_EN
        chk("perf br_cnt", {96'h0, br_cnt}, 128'd3);
        chk("perf mispred_cnt", {96'h0, mispred_cnt}, 128'd1);
`else
        chk("perf br_cnt tied", {96'h0, br_cnt}, 128'd0);
        chk("perf mispred_cnt tied", {96'h0, mispred_cnt}, 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
